// File: rtl/feature_packer_pkg.sv
// Shared definitions for the feature packer: FSM state encoding and the
// width of the saturating frame counters.
package feature_packer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_DROP = 2'd2
  } pack_state_t;

endpackage

// File: rtl/feature_packer_sat_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module sat_counter
  import feature_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/feature_packer.sv
// Collects a framed stream of signed words into one packed feature vector,
// emitting a single-cycle m_valid per well-formed frame and flagging bad frames.
module feature_packer
  import feature_packer_pkg::*;
#(
  parameter int N_FEATURES = 8,
  parameter int WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  output logic [WIDTH*N_FEATURES-1:0] m_x_flat,
  output logic                        frame_err,
  output logic [CNT_W-1:0]            ok_cnt,
  output logic [CNT_W-1:0]            err_cnt
);

  localparam int IDX_W = (N_FEATURES > 2) ? $clog2(N_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEATURES - 1);

  pack_state_t                          state;
  logic [IDX_W-1:0]                     idx;
  logic [N_FEATURES-1:0][WIDTH-1:0]     staging;
  logic [N_FEATURES-1:0][WIDTH-1:0]     next_vec;
  logic                                 xfer;
  logic                                 at_end;
  logic                                 ok_inc;
  logic                                 err_inc;

  assign xfer    = s_valid & s_ready;
  assign at_end  = (idx == LAST_IDX);
  assign ok_inc  = (state == ST_FILL) && xfer && s_last && at_end;
  // Short frame (last too early) or long frame (no last at the final slot).
  assign err_inc = (state == ST_FILL) && xfer && (s_last != at_end);

  // The final word goes straight to the output, bypassing the staging register.
  always_comb begin
    next_vec      = staging;
    next_vec[idx] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      idx       <= '0;
      staging   <= '0;
      m_x_flat  <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      s_ready   <= 1'b1;
    end else begin
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_FILL: begin
          if (xfer) begin
            staging[idx] <= s_data;
            if (s_last || at_end) begin
              idx <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
            if (ok_inc) begin
              state    <= ST_EMIT;
              m_valid  <= 1'b1;
              m_x_flat <= next_vec;
              s_ready  <= 1'b0;
            end else if (err_inc) begin
              frame_err <= 1'b1;
              if (!s_last) begin
                state <= ST_DROP;
              end
            end
          end
        end
        ST_EMIT: begin
          state   <= ST_FILL;
          s_ready <= 1'b1;
        end
        ST_DROP: begin
          if (xfer && s_last) begin
            state <= ST_FILL;
          end
        end
        default: begin
          state   <= ST_FILL;
          idx     <= '0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  sat_counter u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ok_inc),
    .count (ok_cnt)
  );

  sat_counter u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (err_cnt)
  );

endmodule

// File: doc/feature_packer.md
FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 SHALL have parameter N_FEATURES, default 8, words per feature vector (>=2).
REQ-002 SHALL have parameter WIDTH, default 32, word width in bits (Q16.16 word by default).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_ready  output  1  packer accepts a word this cycle.
REQ-007 SHALL have port s_data  input  WIDTH  signed feature word.
REQ-008 SHALL have port s_last  input  1  marks the final word of a frame.
REQ-009 SHALL have port m_valid  output  1  one-cycle pulse: m_x_flat holds a complete vector; drives the MAC's valid_i.
REQ-010 SHALL have port m_x_flat  output  WIDTH*N_FEATURES  packed vector; word k at bits [(k+1)*WIDTH-1 : k*WIDTH]; drives the MAC's x_flat.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-012 SHALL have port ok_cnt  output  16  count of emitted vectors, saturating at 16'hFFFF.
REQ-013 SHALL have port err_cnt  output  16  count of malformed frames, saturating at 16'hFFFF.

Function
REQ-014 SHALL accept a word only on a cycle with s_valid=1 and s_ready=1 (transfer).
REQ-015 SHALL implement states FILL, EMIT and DROP.
REQ-016 In FILL, s_ready SHALL be 1, and each transfer SHALL write s_data into the staging slot at index idx, then increment idx.
REQ-017 In FILL, a transfer at idx=N_FEATURES-1 with s_last=1 SHALL move to EMIT and reset idx to 0.
REQ-018 In FILL, a transfer at idx<N_FEATURES-1 with s_last=1 (short frame) SHALL pulse frame_err on the next cycle, increment err_cnt, reset idx to 0, stay in FILL, and leave m_x_flat unchanged.
REQ-019 In FILL, a transfer at idx=N_FEATURES-1 with s_last=0 (long frame) SHALL pulse frame_err on the next cycle, increment err_cnt, reset idx to 0, and move to DROP.
REQ-020 In DROP, s_ready SHALL be 1 and words SHALL be discarded; a transfer with s_last=1 SHALL return the block to FILL.
REQ-021 In EMIT, s_ready SHALL be 0 for exactly one cycle.
  - On entry to EMIT, m_x_flat SHALL take the staging contents and m_valid SHALL be 1.
  - ok_cnt SHALL increment.
  - The next state SHALL be FILL.
REQ-022 Latency from the transfer of the last word to m_valid=1 SHALL be exactly 1 cycle; the minimum frame period SHALL be N_FEATURES+1 cycles.
REQ-023 m_x_flat SHALL change only on an EMIT cycle and SHALL otherwise hold its last value.
REQ-024 m_valid SHALL never be high on two consecutive cycles.
REQ-025 frame_err and m_valid SHALL never be high on the same cycle.
REQ-026 s_valid=0 SHALL stall the block without losing idx or staging contents.
REQ-027 When a counter reaches 16'hFFFF, further increments SHALL leave it at 16'hFFFF.
REQ-028 s_ready SHALL be a registered function of state only, with no combinational path from s_valid.

Reset
REQ-029 While rst_n=0, the block SHALL be in state FILL with idx=0.
REQ-030 While rst_n=0, the outputs SHALL be:
  - m_valid=0, frame_err=0;
  - m_x_flat=0, ok_cnt=0, err_cnt=0;
  - staging=0, s_ready=1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.

Structure
REQ-032 The state encoding (FILL/EMIT/DROP) and the counter width constant (16) SHALL live in the shared fixed-point package.
REQ-033 A single sub-module sat_counter (16-bit, increment enable, saturating) SHALL be instantiated twice, once for ok_cnt and once for err_cnt.

Verification
REQ-034 Basic frame: N=8, send words 1..8 back-to-back with s_last on word 8.
  - Expect m_valid one cycle later.
  - Expect m_x_flat[31:0]=1 and m_x_flat[255:224]=8.
  - Expect ok_cnt=1.
REQ-035 Stall pattern: s_valid toggled 1/0 through a frame of 32'h0001_0000 (1.0) words.
  - Expect the identical vector.
  - Expect one m_valid pulse.
  - Expect s_ready=0 only on the EMIT cycle.
REQ-036 Short frame: s_last on word 3.
  - Expect one frame_err pulse and err_cnt=1.
  - Expect no m_valid.
  - The next 8-word frame SHALL emit correctly.
REQ-037 Long frame: 11 words with s_last on word 11.
  - Expect frame_err after word 8.
  - Expect words 9-11 dropped.
  - The following valid frame SHALL emit with ok_cnt incremented.
REQ-038 Reset mid-frame: assert rst_n=0 after word 5, release, then send a full frame.
  - Expect all outputs at reset values during reset.
  - Expect a single correct vector afterwards.
REQ-039 Saturation: force ok_cnt to 16'hFFFE, then send 3 frames.
  - Expect ok_cnt=16'hFFFF held.
  - Expect m_valid pulsed 3 times.
